// File: rtl/lagd_energy_feeder.sv
// Upstream feeder for the energy-history FIFO: windowed push/evict of solver
// energies plus best-energy tracking and stall-based convergence detection.
module lagd_energy_feeder #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned STALL_LIMIT = 16,
  parameter int unsigned CNT_WIDTH   = $clog2(STALL_LIMIT + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         en_i,
  input  logic                         flush_i,
  input  logic                         energy_valid_i,
  output logic                         energy_ready_o,
  input  logic signed [DATA_WIDTH-1:0] energy_i,
  input  logic                         energy_skip_i,
  input  logic                         fifo_full_i,
  output logic                         fifo_push_o,
  output logic                         fifo_push_none_o,
  output logic                         fifo_pop_o,
  output logic                         fifo_flush_o,
  output logic        [DATA_WIDTH-1:0] fifo_data_o,
  output logic signed [DATA_WIDTH-1:0] best_energy_o,
  output logic        [CNT_WIDTH-1:0]  stall_cnt_o,
  output logic                         converged_o
);

  typedef enum logic [1:0] {
    S_RUN,
    S_ISSUE,
    S_EVICT_PUSH,
    S_DONE
  } state_e;

  localparam logic signed [DATA_WIDTH-1:0] BEST_INIT = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [CNT_WIDTH-1:0]         STALL_MAX = CNT_WIDTH'(STALL_LIMIT);

  state_e                         state_q, state_d;
  logic signed [DATA_WIDTH-1:0]   sample_q, sample_d;
  logic                           skip_q, skip_d;
  logic signed [DATA_WIDTH-1:0]   best_q, best_d;
  logic [CNT_WIDTH-1:0]           stall_q, stall_d;
  logic                           conv_q, conv_d;
  logic                           handshake;
  logic                           push_slot;

  // Intake is only open in S_RUN; a flush cycle never accepts a sample.
  assign energy_ready_o = (state_q == S_RUN) & en_i & ~flush_i;
  assign handshake      = energy_valid_i & energy_ready_o;

  // Next-state: capture, best/stall bookkeeping, push/evict sequencing.
  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    skip_d   = skip_q;
    best_d   = best_q;
    stall_d  = stall_q;
    conv_d   = conv_q;

    if (flush_i) begin
      state_d = S_RUN;
      best_d  = BEST_INIT;
      stall_d = '0;
      conv_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (handshake) begin
            sample_d = energy_i;
            skip_d   = energy_skip_i;
            state_d  = S_ISSUE;
            if (!energy_skip_i) begin
              if (energy_i < best_q) begin
                best_d  = energy_i;
                stall_d = '0;
              end else if (stall_q != STALL_MAX) begin
                stall_d = stall_q + CNT_WIDTH'(1);
              end
            end
            conv_d = conv_q | (stall_d == STALL_MAX);
          end
        end
        S_ISSUE: begin
          if (fifo_full_i) begin
            state_d = S_EVICT_PUSH;
          end else begin
            state_d = conv_q ? S_DONE : S_RUN;
          end
        end
        S_EVICT_PUSH: begin
          state_d = conv_q ? S_DONE : S_RUN;
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_RUN;
      sample_q <= '0;
      skip_q   <= 1'b0;
      best_q   <= BEST_INIT;
      stall_q  <= '0;
      conv_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      skip_q   <= skip_d;
      best_q   <= best_d;
      stall_q  <= stall_d;
      conv_q   <= conv_d;
    end
  end

  // Strobes decode from state and must react to full/flush in the same cycle.
  assign push_slot = ~flush_i &
                     (((state_q == S_ISSUE) & ~fifo_full_i) | (state_q == S_EVICT_PUSH));

  assign fifo_push_o      = push_slot;
  assign fifo_push_none_o = push_slot & skip_q;
  assign fifo_pop_o       = ~flush_i & (state_q == S_ISSUE) & fifo_full_i;
  assign fifo_flush_o     = flush_i;
  assign fifo_data_o      = sample_q;

  assign best_energy_o = best_q;
  assign stall_cnt_o   = stall_q;
  assign converged_o   = conv_q;

  // Evict and push are sequenced in separate cycles.
  a_no_push_pop: assert property (@(posedge clk_i) disable iff (rst_i)
    !(fifo_push_o && fifo_pop_o));

endmodule
